riva_vldu_rtracker: RTL and testbench

Load-side AXI read-beat tracker between the vector address generator and the vector load unit (VLDU). Buffers `addrgen_axi_req_t` descriptors issued on AR, then annotates each returning R beat with its byte offset within the DLEN-wide bus, valid byte count, and last-of-burst flag, so the VLDU can shuffle bytes into lanes without re-deriving address arithmetic. Exception descriptors are forwarded in order as dataless tokens.

---
 rtl/riva_pkg.sv | 39 +++
 rtl/riva_fifo.sv | 43 ++++
 rtl/riva_vldu_rtracker.sv | 109 ++++++++++
 tb/tb_riva_vldu_rtracker.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riva_pkg.sv
// Shared types and constants for the RIVA vector load path.
// No logic beyond a pure helper function; widths derive from DLEN.
package riva_pkg;

  localparam int unsigned DLEN                   = 128;
  localparam int unsigned DlenB                  = DLEN / 8;
  localparam int unsigned DlenBLog2              = $clog2(DlenB);
  localparam int unsigned AddrWidth              = 32;
  localparam int unsigned VaddrgenInsnQueueDepth = 4;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [2:0]           size;
    logic [7:0]           len;
    logic                 is_load;
    logic                 is_exception;
  } addrgen_axi_req_t;

  typedef struct packed {
    logic [DLEN-1:0]      data;
    logic [DlenBLog2-1:0] start_byte;
    logic [DlenBLog2:0]   nbytes;
    logic                 last;
    logic                 exc;
  } vldu_beat_t;

  // Only the bus-offset bits of the address matter once a burst is queued.
  typedef struct packed {
    logic [DlenBLog2-1:0] addr_off;
    logic [2:0]           size;
    logic [7:0]           len;
    logic                 exc;
  } rtrk_entry_t;

  function automatic logic [DlenBLog2:0] beat_bytes(input logic [2:0] size);
    return (DlenBLog2 + 1)'(1) << size;
  endfunction

endpackage

// File: rtl/riva_fifo.sv
// Generic registered FIFO: push visible at the head one cycle later, no fall-through.
// Push is refused while full and pop is ignored while empty; full/empty are register-derived.
module riva_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned Aw = $clog2(Depth);

  T           mem [Depth];
  logic [Aw:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr_q[Aw-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q[Aw-1:0]] <= wdata;
  end

endmodule

// File: rtl/riva_vldu_rtracker.sv
// Annotates AXI R beats with byte offset/count/last from queued AR descriptors; zero-latency R path.
// R and descriptor backpressure: r_ready follows beat_ready while a load heads the queue; desc_ready = !full.
module riva_vldu_rtracker
  import riva_pkg::*;
#(
  parameter int unsigned DescDepth    = VaddrgenInsnQueueDepth,
  parameter int unsigned AxiDataWidth = DLEN
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  addrgen_axi_req_t        desc_i,
  input  logic                    desc_valid_i,
  output logic                    desc_ready_o,
  input  logic [AxiDataWidth-1:0] r_data_i,
  input  logic                    r_last_i,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  output vldu_beat_t              beat_o,
  output logic                    beat_valid_o,
  input  logic                    beat_ready_i,
  output logic                    idle_o,
  output logic                    err_o
);

  rtrk_entry_t          in_entry, head;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                 head_vld, data_vld, beat_fire, first_beat, beat_last;
  logic [7:0]           beat_cnt_q;
  logic [DlenBLog2-1:0] cur_off_q, start_byte;
  logic [DlenBLog2:0]   size_bytes, misalign, nbytes;
  logic                 err_q;
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^desc_i.addr[AddrWidth-1:DlenBLog2];

  assign in_entry.addr_off = desc_i.addr[DlenBLog2-1:0];
  assign in_entry.size     = desc_i.size;
  assign in_entry.len      = desc_i.len;
  assign in_entry.exc      = desc_i.is_exception;

  // Non-load descriptors are acknowledged but never queued.
  assign desc_ready_o = ~fifo_full;
  assign fifo_push    = desc_valid_i & ~fifo_full & desc_i.is_load;

  riva_fifo #(
    .T     (rtrk_entry_t),
    .Depth (DescDepth)
  ) u_desc_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fifo_push),
    .wdata  (in_entry),
    .pop    (fifo_pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign head_vld = ~fifo_empty;
  assign data_vld = head_vld & ~head.exc;

  always_comb begin
    size_bytes = beat_bytes(head.size);
    misalign   = {1'b0, head.addr_off} & (size_bytes - (DlenBLog2 + 1)'(1));
    first_beat = (beat_cnt_q == 8'd0);
    // The first beat of a burst starts at the address itself, possibly mid-element.
    start_byte = first_beat ? head.addr_off : cur_off_q;
    nbytes     = first_beat ? (size_bytes - misalign) : size_bytes;
    beat_last  = (beat_cnt_q == head.len);

    r_ready_o    = beat_ready_i & data_vld;
    beat_valid_o = head_vld & (head.exc | r_valid_i);
    beat_fire    = r_valid_i & r_ready_o;
    fifo_pop     = (beat_fire & beat_last) | (head_vld & head.exc & beat_ready_i);

    beat_o = '0;
    if (beat_valid_o) begin
      if (head.exc) begin
        beat_o.last = 1'b1;
        beat_o.exc  = 1'b1;
      end else begin
        beat_o.data       = r_data_i;
        beat_o.start_byte = start_byte;
        beat_o.nbytes     = nbytes;
        beat_o.last       = beat_last;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
      cur_off_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if (beat_fire) begin
        beat_cnt_q <= beat_last ? 8'd0 : beat_cnt_q + 8'd1;
        // Truncation to the offset width gives the wrap around the bus width.
        cur_off_q  <= start_byte + nbytes[DlenBLog2-1:0];
      end
      if ((beat_fire && (r_last_i != beat_last)) || (r_valid_i && fifo_empty))
        err_q <= 1'b1;
    end
  end

  assign idle_o = fifo_empty & (beat_cnt_q == 8'd0);
  assign err_o  = err_q;

endmodule

// File: tb/tb_riva_vldu_rtracker.sv
// Directed bench for riva_vldu_rtracker: inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_riva_vldu_rtracker;
  import riva_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  addrgen_axi_req_t desc_i;
  logic             desc_valid_i;
  logic             desc_ready_o;
  logic [DLEN-1:0]  r_data_i;
  logic             r_last_i;
  logic             r_valid_i;
  logic             r_ready_o;
  vldu_beat_t       beat_o;
  logic             beat_valid_o;
  logic             beat_ready_i;
  logic             idle_o;
  logic             err_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  riva_vldu_rtracker #(
    .DescDepth    (4),
    .AxiDataWidth (DLEN)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .desc_i       (desc_i),
    .desc_valid_i (desc_valid_i),
    .desc_ready_o (desc_ready_o),
    .r_data_i     (r_data_i),
    .r_last_i     (r_last_i),
    .r_valid_i    (r_valid_i),
    .r_ready_o    (r_ready_o),
    .beat_o       (beat_o),
    .beat_valid_o (beat_valid_o),
    .beat_ready_i (beat_ready_i),
    .idle_o       (idle_o),
    .err_o        (err_o)
  );

  function automatic addrgen_axi_req_t mk_desc(input logic [31:0] addr, input logic [2:0] size,
                                               input logic [7:0] len, input logic ld, input logic exc);
    addrgen_axi_req_t d;
    d.addr = addr; d.size = size; d.len = len; d.is_load = ld; d.is_exception = exc;
    return d;
  endfunction

  function automatic vldu_beat_t mk_beat(input logic [DLEN-1:0] data, input logic [3:0] start,
                                         input logic [4:0] nb, input logic last, input logic exc);
    vldu_beat_t b;
    b.data = data; b.start_byte = start; b.nbytes = nb; b.last = last; b.exc = exc;
    return b;
  endfunction

  function automatic logic [DLEN-1:0] pat(input int i);
    return {4{32'hA5A5_0000 + 32'(i)}};
  endfunction

  task automatic push_desc(input addrgen_axi_req_t d);
    @(negedge clk_i);
    desc_i       = d;
    desc_valid_i = 1'b1;
    @(negedge clk_i);
    desc_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    #1;
    vectors++; if (desc_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset desc_ready: got %b want 1", desc_ready_o); end
    vectors++; if (r_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset r_ready: got %b want 0", r_ready_o); end
    vectors++; if (beat_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset beat_valid: got %b want 0", beat_valid_o); end
    vectors++; if (beat_o !== '0) begin miscompares++; $display("FAIL reset beat: got %h want 0", beat_o); end
    vectors++; if (idle_o !== 1'b1) begin miscompares++; $display("FAIL reset idle: got %b want 1", idle_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset err: got %b want 0", err_o); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_aligned;
    vldu_beat_t exp;
    push_desc(mk_desc(32'h100, 3'd4, 8'd3, 1'b1, 1'b0));
    #1;
    vectors++; if (idle_o !== 1'b0) begin miscompares++; $display("FAIL aligned idle_busy: got %b want 0", idle_o); end
    for (int i = 0; i < 4; i++) begin
      r_data_i = pat(i); r_last_i = (i == 3); r_valid_i = 1'b1;
      #1;
      exp = mk_beat(pat(i), 4'd0, 5'd16, (i == 3), 1'b0);
      vectors++; if (beat_o !== exp || beat_valid_o !== 1'b1 || r_ready_o !== 1'b1) begin
        miscompares++; $display("FAIL aligned beat%0d: got %h v=%b rr=%b want %h v=1 rr=1", i, beat_o, beat_valid_o, r_ready_o, exp);
      end
      @(negedge clk_i);
    end
    r_valid_i = 1'b0;
    #1;
    vectors++; if (idle_o !== 1'b1) begin miscompares++; $display("FAIL aligned idle_after: got %b want 1", idle_o); end
  endtask

  task automatic test_drop_nonload;
    push_desc(mk_desc(32'h180, 3'd4, 8'd0, 1'b0, 1'b0));
    #1;
    vectors++; if (idle_o !== 1'b1) begin miscompares++; $display("FAIL drop_nonload idle: got %b want 1", idle_o); end
  endtask

  // Misaligned burst followed immediately by a wrapping one, streamed with no idle cycle.
  task automatic test_back_to_back;
    int         s [6] = '{6, 8, 12, 12, 0, 4};
    int         n [6] = '{2, 4, 4, 4, 4, 4};
    logic       l [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vldu_beat_t exp;
    push_desc(mk_desc(32'h106, 3'd2, 8'd2, 1'b1, 1'b0));
    push_desc(mk_desc(32'h10C, 3'd2, 8'd2, 1'b1, 1'b0));
    for (int i = 0; i < 6; i++) begin
      r_data_i = pat(10 + i); r_last_i = l[i]; r_valid_i = 1'b1;
      #1;
      exp = mk_beat(pat(10 + i), 4'(s[i]), 5'(n[i]), l[i], 1'b0);
      vectors++; if (beat_o !== exp || beat_valid_o !== 1'b1) begin
        miscompares++; $display("FAIL b2b beat%0d: got %h v=%b want %h v=1", i, beat_o, beat_valid_o, exp);
      end
      @(negedge clk_i);
    end
    r_valid_i = 1'b0;
    #1;
    vectors++; if (idle_o !== 1'b1 || err_o !== 1'b0) begin miscompares++; $display("FAIL b2b done: idle=%b err=%b want idle=1 err=0", idle_o, err_o); end
  endtask

  task automatic test_exception;
    vldu_beat_t exp;
    push_desc(mk_desc(32'h200, 3'd4, 8'd0, 1'b1, 1'b0));
    push_desc(mk_desc(32'h240, 3'd4, 8'd0, 1'b1, 1'b1));
    push_desc(mk_desc(32'h204, 3'd2, 8'd0, 1'b1, 1'b0));
    r_data_i = pat(20); r_last_i = 1'b1; r_valid_i = 1'b1;
    #1;
    exp = mk_beat(pat(20), 4'd0, 5'd16, 1'b1, 1'b0);
    vectors++; if (beat_o !== exp) begin miscompares++; $display("FAIL exc load0: got %h want %h", beat_o, exp); end
    @(negedge clk_i);
    r_data_i = pat(21);
    #1;
    exp = mk_beat('0, 4'd0, 5'd0, 1'b1, 1'b1);
    vectors++; if (beat_o !== exp || beat_valid_o !== 1'b1) begin miscompares++; $display("FAIL exc token: got %h v=%b want %h v=1", beat_o, beat_valid_o, exp); end
    vectors++; if (r_ready_o !== 1'b0) begin miscompares++; $display("FAIL exc r_ready: got %b want 0", r_ready_o); end
    @(negedge clk_i);
    #1;
    exp = mk_beat(pat(21), 4'd4, 5'd4, 1'b1, 1'b0);
    vectors++; if (beat_o !== exp || r_ready_o !== 1'b1) begin miscompares++; $display("FAIL exc load1: got %h rr=%b want %h rr=1", beat_o, r_ready_o, exp); end
    @(negedge clk_i);
    r_valid_i = 1'b0;
    #1;
    vectors++; if (idle_o !== 1'b1 || err_o !== 1'b0) begin miscompares++; $display("FAIL exc done: idle=%b err=%b want idle=1 err=0", idle_o, err_o); end
  endtask

  task automatic test_full;
    vldu_beat_t exp;
    beat_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_desc(mk_desc(32'h600 + 32'(16 * i), 3'd4, 8'd0, 1'b1, 1'b0));
    #1;
    vectors++; if (desc_ready_o !== 1'b0) begin miscompares++; $display("FAIL full ready: got %b want 0", desc_ready_o); end
    // Pop one while offering a fifth descriptor: it must be refused this cycle.
    beat_ready_i = 1'b1; r_valid_i = 1'b1; r_last_i = 1'b1; r_data_i = pat(40);
    desc_i = mk_desc(32'h700, 3'd4, 8'd0, 1'b1, 1'b0); desc_valid_i = 1'b1;
    #1;
    vectors++; if (desc_ready_o !== 1'b0) begin miscompares++; $display("FAIL full ready_on_pop: got %b want 0", desc_ready_o); end
    exp = mk_beat(pat(40), 4'd0, 5'd16, 1'b1, 1'b0);
    vectors++; if (beat_o !== exp) begin miscompares++; $display("FAIL full pop_beat: got %h want %h", beat_o, exp); end
    @(negedge clk_i);
    desc_valid_i = 1'b0; r_valid_i = 1'b0;
    #1;
    vectors++; if (desc_ready_o !== 1'b1) begin miscompares++; $display("FAIL full ready_return: got %b want 1", desc_ready_o); end
    r_valid_i = 1'b1;
    repeat (3) @(negedge clk_i);
    r_valid_i = 1'b0;
    #1;
    vectors++; if (idle_o !== 1'b1) begin miscompares++; $display("FAIL full drained_idle: got %b want 1", idle_o); end
  endtask

  task automatic test_last_mismatch;
    vldu_beat_t exp;
    push_desc(mk_desc(32'h300, 3'd4, 8'd2, 1'b1, 1'b0));
    r_valid_i = 1'b1; r_last_i = 1'b0; r_data_i = pat(50);
    @(negedge clk_i);
    r_last_i = 1'b1; r_data_i = pat(51);
    #1;
    vectors++; if (err_o !== 1'b0 || beat_o.last !== 1'b0) begin miscompares++; $display("FAIL lastmm pre: err=%b last=%b want err=0 last=0", err_o, beat_o.last); end
    @(negedge clk_i);
    r_data_i = pat(52);
    #1;
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL lastmm err_set: got %b want 1", err_o); end
    exp = mk_beat(pat(52), 4'd0, 5'd16, 1'b1, 1'b0);
    vectors++; if (beat_o !== exp) begin miscompares++; $display("FAIL lastmm beat2: got %h want %h", beat_o, exp); end
    @(negedge clk_i);
    r_valid_i = 1'b0;
    #1;
    vectors++; if (idle_o !== 1'b1 || err_o !== 1'b1) begin miscompares++; $display("FAIL lastmm done: idle=%b err=%b want idle=1 err=1", idle_o, err_o); end
  endtask

  task automatic test_reset_mid_burst;
    vldu_beat_t exp;
    push_desc(mk_desc(32'h400, 3'd4, 8'd3, 1'b1, 1'b0));
    r_valid_i = 1'b1; r_last_i = 1'b0; r_data_i = pat(60);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    vectors++; if (beat_valid_o !== 1'b0 || r_ready_o !== 1'b0 || beat_o !== '0) begin
      miscompares++; $display("FAIL midrst beat: v=%b rr=%b beat=%h want 0 0 0", beat_valid_o, r_ready_o, beat_o);
    end
    vectors++; if (idle_o !== 1'b1 || err_o !== 1'b0 || desc_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL midrst status: idle=%b err=%b dr=%b want 1 0 1", idle_o, err_o, desc_ready_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1; r_valid_i = 1'b0;
    push_desc(mk_desc(32'h508, 3'd3, 8'd2, 1'b1, 1'b0));
    r_valid_i = 1'b1; r_last_i = 1'b0; r_data_i = pat(61);
    #1;
    exp = mk_beat(pat(61), 4'd8, 5'd8, 1'b0, 1'b0);
    vectors++; if (beat_o !== exp) begin miscompares++; $display("FAIL midrst restart0: got %h want %h", beat_o, exp); end
    @(negedge clk_i);
    r_data_i = pat(62);
    #1;
    exp = mk_beat(pat(62), 4'd0, 5'd8, 1'b0, 1'b0);
    vectors++; if (beat_o !== exp) begin miscompares++; $display("FAIL midrst restart1: got %h want %h", beat_o, exp); end
    @(negedge clk_i);
    r_data_i = pat(63); r_last_i = 1'b1;
    #1;
    exp = mk_beat(pat(63), 4'd8, 5'd8, 1'b1, 1'b0);
    vectors++; if (beat_o !== exp) begin miscompares++; $display("FAIL midrst restart2: got %h want %h", beat_o, exp); end
    @(negedge clk_i);
    r_valid_i = 1'b0;
    #1;
    vectors++; if (idle_o !== 1'b1 || err_o !== 1'b0) begin miscompares++; $display("FAIL midrst done: idle=%b err=%b want idle=1 err=0", idle_o, err_o); end
  endtask

  task automatic test_r_without_desc;
    @(negedge clk_i);
    r_valid_i = 1'b1; r_last_i = 1'b1;
    #1;
    vectors++; if (r_ready_o !== 1'b0 || beat_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL stray_r handshake: rr=%b v=%b want 0 0", r_ready_o, beat_valid_o);
    end
    @(negedge clk_i);
    r_valid_i = 1'b0;
    #1;
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL stray_r err: got %b want 1", err_o); end
  endtask

  initial begin
    desc_i = '0; desc_valid_i = 1'b0; r_data_i = '0; r_last_i = 1'b0;
    r_valid_i = 1'b0; beat_ready_i = 1'b1;
    test_reset();
    test_aligned();
    test_drop_nonload();
    test_back_to_back();
    test_exception();
    test_full();
    test_last_mismatch();
    test_reset_mid_burst();
    test_r_without_desc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d vectors applied", vectors);
    $fatal(1);
  end

endmodule
